// File: rtl/lb_pkg.sv
// rtl/lb_pkg.sv - shared line-buffer widths, sample/sum types and averaging FSM states
package lb_pkg;

    localparam int LB_TAPS  = 8;
    localparam int LB_DW    = 8;
    localparam int LB_SHIFT = $clog2(LB_TAPS);
    localparam int LB_SW    = LB_DW + LB_SHIFT;

    typedef logic [LB_DW-1:0] lb_sample_t;
    typedef logic [LB_SW-1:0] lb_sum_t;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } lb_state_e;

endpackage

// File: rtl/lbavg_div.sv
// rtl/lbavg_div.sv - window sum to sample-width average: shift, optional half-up round, saturate
//
// Ports:
//   sum_i : window sum (lb_sum_t width)
//   avg_o : sum / LB_TAPS, rounded half-up when ROUND = 1, truncated otherwise,
//           clamped to the largest sample value
module lbavg_div
    import lb_pkg::*;
#(
    parameter bit ROUND = 1'b1
) (
    input  logic [LB_SW-1:0] sum_i,
    output logic [LB_DW-1:0] avg_o
);

    // One extra bit so the rounding bias can never wrap the sum.
    localparam logic [LB_SW:0] BIAS = ROUND ? (LB_SW+1)'(LB_TAPS / 2) : '0;
    localparam logic [LB_SW:0] SAT  = (LB_SW+1)'((1 << LB_DW) - 1);

    logic [LB_SW:0] biased;
    logic [LB_SW:0] shifted;

    always_comb begin
        biased  = {1'b0, sum_i} + BIAS;
        shifted = biased >> LB_SHIFT;
        if (shifted > SAT) begin
            avg_o = '1;
        end else begin
            avg_o = shifted[LB_DW-1:0];
        end
    end

endmodule

// File: rtl/lbavg.sv
// rtl/lbavg.sv - eight-sample moving sum / average tap on the line-buffer write stream
//
// Ports:
//   CLK, ASYNCRESETN    : clock, asynchronous active-low reset
//   in_data, in_wen     : sample written to the line buffer and its write strobe
//   lb_rdata, lb_valid  : oldest sample of the current window from the line buffer
//   out_sum, out_avg    : registered window sum and average, held between windows
//   out_valid           : one-cycle pulse per produced window
//   err                 : sticky protocol-violation flag, cleared only by reset
module lbavg
    import lb_pkg::*;
#(
    parameter bit ROUND = 1'b1
) (
    input  logic              CLK,
    input  logic              ASYNCRESETN,
    input  logic [LB_DW-1:0]  in_data,
    input  logic              in_wen,
    input  logic [LB_DW-1:0]  lb_rdata,
    input  logic              lb_valid,
    output logic [LB_SW-1:0]  out_sum,
    output logic [LB_DW-1:0]  out_avg,
    output logic              out_valid,
    output logic              err
);

    lb_state_e  state_q;
    logic [2:0] fill_q;
    lb_sum_t    acc_q;      // sum of the newest seven accepted samples
    lb_sum_t    out_sum_q;
    lb_sample_t out_avg_q;
    logic       out_valid_q;
    logic       err_q;

    lb_sum_t    win_sum;
    lb_sample_t win_avg;

    // Full window = running seven-sample sum plus the sample being written now.
    assign win_sum = acc_q + LB_SW'(in_data);

    lbavg_div #(
        .ROUND (ROUND)
    ) u_div (
        .sum_i (win_sum),
        .avg_o (win_avg)
    );

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q     <= FILL;
            fill_q      <= '0;
            acc_q       <= '0;
            out_sum_q   <= '0;
            out_avg_q   <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                FILL: begin
                    // The line buffer cannot have an oldest sample before seven writes.
                    if (lb_valid) begin
                        err_q   <= 1'b1;
                        state_q <= ERR;
                    end else if (in_wen) begin
                        acc_q  <= acc_q + LB_SW'(in_data);
                        fill_q <= fill_q + 3'd1;
                        if (fill_q == 3'(LB_TAPS - 2)) begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (in_wen && lb_valid) begin
                        out_sum_q   <= win_sum;
                        out_avg_q   <= win_avg;
                        out_valid_q <= 1'b1;
                        // Drop the oldest sample; it is part of win_sum so this never underflows.
                        acc_q       <= win_sum - LB_SW'(lb_rdata);
                    end else if (in_wen || lb_valid) begin
                        // Write without a read, or a drain read without a write.
                        err_q   <= 1'b1;
                        state_q <= ERR;
                    end
                end
                ERR: begin
                    state_q <= ERR;
                end
                default: begin
                    err_q   <= 1'b1;
                    state_q <= ERR;
                end
            endcase
        end
    end

    assign out_sum   = out_sum_q;
    assign out_avg   = out_avg_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_lbavg.sv
// tb/tb_lbavg.sv - self-checking bench for lbavg with line-buffer model and scoreboard
module tb_lbavg;

    localparam bit RND = 1'b1;

    logic        CLK = 1'b0;
    logic        ASYNCRESETN = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_wen = 1'b0;
    logic [7:0]  lb_rdata = '0;
    logic        lb_valid = 1'b0;
    logic [10:0] out_sum;
    logic [7:0]  out_avg;
    logic        out_valid;
    logic        err;

    lbavg #(.ROUND(RND)) dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .in_data     (in_data),
        .in_wen      (in_wen),
        .lb_rdata    (lb_rdata),
        .lb_valid    (lb_valid),
        .out_sum     (out_sum),
        .out_avg     (out_avg),
        .out_valid   (out_valid),
        .err         (err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic v;
        int   s;
        int   a;
        logic e;
    } exp_t;

    typedef struct {
        logic       wen;
        logic [7:0] data;
        logic       ev;
        int         es;
        int         ea;
    } tvec_t;

    exp_t  sb[$];
    int    hist[$];
    int    m_writes;
    logic  m_err;
    int    m_sum;
    int    m_avg;
    int    n_checks = 0;
    int    n_fail = 0;
    tvec_t tbl[11];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_avg(input int s);
        int r;
        r = RND ? (s + 4) / 8 : s / 8;
        if (r > 255) r = 255;
        return r;
    endfunction

    task automatic model_reset();
        hist.delete();
        sb.delete();
        m_writes = 0;
        m_err    = 1'b0;
        m_sum    = 0;
        m_avg    = 0;
    endtask

    // One clock: line-buffer model drives lb_*, reference model pushes the
    // expectation, and after the edge the scoreboard pops and compares.
    task automatic cyc(input logic wen, input logic [7:0] d, input logic force_v);
        exp_t e;
        int   n;
        int   s;
        logic lbv;
        n   = hist.size();
        lbv = force_v | (wen && n >= 7);
        e.v = 1'b0;
        if (!m_err) begin
            if (m_writes < 7) begin
                if (lbv) m_err = 1'b1;
                else if (wen) m_writes++;
            end else if (wen != lbv) begin
                m_err = 1'b1;
            end else if (wen) begin
                s = d;
                for (int i = n - 7; i < n; i++) s += hist[i];
                m_sum = s;
                m_avg = ref_avg(s);
                e.v   = 1'b1;
            end
        end
        e.s = m_sum;
        e.a = m_avg;
        e.e = m_err;
        sb.push_back(e);
        in_wen   = wen;
        in_data  = d;
        lb_valid = lbv;
        lb_rdata = (n >= 7) ? 8'(hist[n-7]) : 8'd0;
        if (wen) hist.push_back(int'(d));
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("out_valid", int'(out_valid), int'(e.v));
            chk("out_sum", int'(out_sum), e.s);
            chk("out_avg", int'(out_avg), e.a);
            chk("err", int'(err), int'(e.e));
        end
        in_wen   = 1'b0;
        lb_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_wen      = 1'b0;
        lb_valid    = 1'b0;
        ASYNCRESETN = 1'b0;
        @(posedge CLK);
        #1;
        model_reset();
        ASYNCRESETN = 1'b1;
    endtask

    initial begin
        int vcnt;
        for (int i = 0; i < 7; i++) tbl[i] = '{1'b1, 8'(i + 1), 1'b0, 0, 0};
        tbl[7]  = '{1'b1, 8'd8,  1'b1, 36, RND ? 5 : 4};
        tbl[8]  = '{1'b1, 8'd9,  1'b1, 44, RND ? 6 : 5};
        tbl[9]  = '{1'b1, 8'd10, 1'b1, 52, RND ? 7 : 6};
        tbl[10] = '{1'b0, 8'd0,  1'b0, 52, RND ? 7 : 6};

        model_reset();
        @(posedge CLK);
        #1;
        chk("rst_sum", int'(out_sum), 0);
        chk("rst_avg", int'(out_avg), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_err", int'(err), 0);
        ASYNCRESETN = 1'b1;

        // Ramp 1..10 then idle.
        foreach (tbl[i]) begin
            cyc(tbl[i].wen, tbl[i].data, 1'b0);
            chk("tbl_valid", int'(out_valid), int'(tbl[i].ev));
            chk("tbl_sum", int'(out_sum), tbl[i].es);
            chk("tbl_avg", int'(out_avg), tbl[i].ea);
        end

        // Full-scale samples: no wrap, no saturation artifacts.
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'd255, 1'b0);
        chk("max_sum", int'(out_sum), 2040);
        chk("max_avg", int'(out_avg), 255);

        // Writes of 10 interleaved with idles, from a fresh start.
        do_reset();
        vcnt = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 8'd10, 1'b0);
            if (out_valid) vcnt++;
            cyc(1'b0, 8'd0, 1'b0);
            chk("idle_valid", int'(out_valid), 0);
        end
        chk("gap_sum", int'(out_sum), 80);
        chk("gap_avg", int'(out_avg), 10);
        chk("gap_windows", vcnt, 5);

        // Line-buffer valid during fill on the 3rd write.
        do_reset();
        cyc(1'b1, 8'd1, 1'b0);
        cyc(1'b1, 8'd2, 1'b0);
        cyc(1'b1, 8'd3, 1'b1);
        chk("err_set", int'(err), 1);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 8'(i + 4), 1'b0);
            chk("err_novalid", int'(out_valid), 0);
        end
        chk("err_sticky", int'(err), 1);
        do_reset();
        chk("err_clear", int'(err), 0);

        // Asynchronous reset between edges, mid-window.
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'(3 * i + 1), 1'b0);
        #2;
        ASYNCRESETN = 1'b0;
        #1;
        chk("arst_sum", int'(out_sum), 0);
        chk("arst_avg", int'(out_avg), 0);
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_err", int'(err), 0);
        @(posedge CLK);
        #1;
        model_reset();
        ASYNCRESETN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 8'd20, 1'b0);
            chk("fresh_valid", int'(out_valid), (i == 7) ? 1 : 0);
        end
        chk("fresh_sum", int'(out_sum), 160);
        chk("fresh_avg", int'(out_avg), 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
